// File: rtl/cordic_phase_sweeper.sv
// Phase stimulus generator for the CORDIC core: sawtooth/triangle sweeps over 0..PHASE_MAX with valid/ready output.
// Defining CORDIC_SWEEP_ERR_MON_EN adds the err input and the running |err| peak output max_err.
module cordic_phase_sweeper #(
    parameter int unsigned PHASE_W   = 16,
    parameter int unsigned PHASE_MAX = 359,
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned SWEEP_W   = 8,
    parameter int unsigned ERR_W     = 32
) (
    input  logic               CLK_50M,
    input  logic               RST_N,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [STEP_W-1:0]  step,
    input  logic [SWEEP_W-1:0] num_sweeps,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    input  logic               phase_ready,
    output logic               busy,
    output logic               sweep_done,
    output logic               all_done,
    output logic [SWEEP_W-1:0] sweep_cnt
`ifdef CORDIC_SWEEP_ERR_MON_EN
    ,
    input  logic signed [ERR_W-1:0] err,
    output logic [ERR_W-1:0]        max_err
`endif
);

    localparam int unsigned EXT_W = PHASE_W + 1;
    localparam logic [EXT_W-1:0] MAX_EXT   = EXT_W'(PHASE_MAX);
    localparam logic [EXT_W-1:0] RANGE_EXT = EXT_W'(PHASE_MAX + 1);

    // IDLE: wait for start | UP: rising phase | DOWN: falling phase (triangle) | DONE: all_done pulse
    typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] phase_d;
    logic               valid_d, sweep_done_d;
    logic [SWEEP_W-1:0] cnt_d, cnt_inc;
    logic               mode_q, mode_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [SWEEP_W-1:0] num_q, num_d;
    logic [EXT_W-1:0]   step_ext, sum, wrap, diff;
    logic               accept, complete, start_ok;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            phase       <= '0;
            phase_valid <= 1'b0;
            sweep_done  <= 1'b0;
            sweep_cnt   <= '0;
            mode_q      <= 1'b0;
            step_q      <= STEP_W'(1);
            num_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase       <= phase_d;
            phase_valid <= valid_d;
            sweep_done  <= sweep_done_d;
            sweep_cnt   <= cnt_d;
            mode_q      <= mode_d;
            step_q      <= step_d;
            num_q       <= num_d;
        end
    end

    assign accept   = phase_valid && phase_ready;
    assign start_ok = (state_q == IDLE) && start && !abort;
    assign step_ext = EXT_W'(step_q);
    assign sum      = {1'b0, phase} + step_ext;
    assign wrap     = sum - RANGE_EXT;
    assign diff     = {1'b0, phase} - step_ext;
    assign cnt_inc  = (&sweep_cnt) ? sweep_cnt : sweep_cnt + SWEEP_W'(1);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase;
        valid_d      = phase_valid;
        sweep_done_d = 1'b0;
        cnt_d        = sweep_cnt;
        mode_d       = mode_q;
        step_d       = step_q;
        num_d        = num_q;
        complete     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    mode_d  = mode;
                    step_d  = (step == '0) ? STEP_W'(1) : step;
                    num_d   = num_sweeps;
                    cnt_d   = '0;
                    phase_d = '0;
                    valid_d = 1'b1;
                    state_d = UP;
                end
            end
            UP: begin
                if (accept) begin
                    if (!mode_q) begin
                        if (sum <= MAX_EXT) begin
                            phase_d = sum[PHASE_W-1:0];
                        end else begin
                            phase_d  = wrap[PHASE_W-1:0];
                            complete = 1'b1;
                        end
                    end else if (sum >= MAX_EXT) begin
                        phase_d = PHASE_W'(PHASE_MAX);
                        state_d = DOWN;
                    end else begin
                        phase_d = sum[PHASE_W-1:0];
                    end
                end
            end
            DOWN: begin
                if (accept) begin
                    if ({1'b0, phase} <= step_ext) begin
                        phase_d  = '0;
                        complete = 1'b1;
                        state_d  = UP;
                    end else begin
                        phase_d = diff[PHASE_W-1:0];
                    end
                end
            end
            DONE: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            sweep_done_d = 1'b1;
            cnt_d        = cnt_inc;
            if ((num_q != '0) && (cnt_inc == num_q)) begin
                state_d = DONE;
                valid_d = 1'b0;
            end
        end

        // Abort overrides everything except the completed-sweep count.
        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            valid_d      = 1'b0;
            phase_d      = '0;
            sweep_done_d = 1'b0;
            cnt_d        = sweep_cnt;
        end
    end

    assign busy     = (state_q != IDLE);
    assign all_done = (state_q == DONE);

`ifdef CORDIC_SWEEP_ERR_MON_EN
    localparam logic [ERR_W-1:0] ERR_POS_MAX = {1'b0, {(ERR_W-1){1'b1}}};
    logic [ERR_W-1:0] err_mag;

    always_comb begin
        err_mag = $unsigned(err);
        if (err == $signed({1'b1, {(ERR_W-1){1'b0}}}))
            err_mag = ERR_POS_MAX;
        else if (err < 0)
            err_mag = $unsigned(-err);
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N)
            max_err <= '0;
        else if (start_ok)
            max_err <= '0;
        else if (accept && !abort && (err_mag > max_err))
            max_err <= err_mag;
    end
`endif

endmodule

// File: tb/tb_cordic_phase_sweeper.sv
// Randomized self-checking bench for cordic_phase_sweeper; expected phase sequences come from a closed-form/walk model.
// Define CORDIC_SWEEP_ERR_MON_EN for both files to also exercise the |err| monitor.
module tb_cordic_phase_sweeper;
    localparam int PW = 16, PMAX = 359, SW = 8, NW = 8, EW = 32;
    localparam int BUDGET = 20000;

    logic          clk_50m = 1'b0;
    logic          rst_n;
    logic          start, abort, mode, phase_ready;
    logic [SW-1:0] step;
    logic [NW-1:0] num_sweeps, sweep_cnt;
    logic [PW-1:0] phase;
    logic          phase_valid, busy, sweep_done, all_done;
`ifdef CORDIC_SWEEP_ERR_MON_EN
    logic signed [EW-1:0] err;
    logic [EW-1:0]        max_err;
    longint               exp_max;
`endif

    int checks = 0;
    int failures = 0;

    int exp_ph[$];
    bit exp_cmp[$];
    int exp_final;

    always #10 clk_50m = ~clk_50m;

    cordic_phase_sweeper #(.PHASE_W(PW), .PHASE_MAX(PMAX), .STEP_W(SW), .SWEEP_W(NW), .ERR_W(EW)) dut (
        .CLK_50M(clk_50m), .RST_N(rst_n), .start(start), .abort(abort), .mode(mode),
        .step(step), .num_sweeps(num_sweeps), .phase(phase), .phase_valid(phase_valid),
        .phase_ready(phase_ready), .busy(busy), .sweep_done(sweep_done), .all_done(all_done),
        .sweep_cnt(sweep_cnt)
`ifdef CORDIC_SWEEP_ERR_MON_EN
        , .err(err), .max_err(max_err)
`endif
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Presented phase values of one run; exp_cmp marks samples whose acceptance completes a sweep.
    task automatic build_expected(input bit m, input int s, input int n, input int limit);
        int se, comp, v;
        bit up;
        exp_ph.delete();
        exp_cmp.delete();
        se = (s == 0) ? 1 : s;
        comp = 0;
        if (!m) begin
            for (int k = 0; k < 100000; k++) begin
                bit c;
                c = ((k + 1) * se) / (PMAX + 1) != (k * se) / (PMAX + 1);
                exp_ph.push_back((k * se) % (PMAX + 1));
                exp_cmp.push_back(c);
                if (c) comp++;
                exp_final = ((k + 1) * se) % (PMAX + 1);
                if ((n != 0 && comp == n) || (n == 0 && exp_ph.size() == limit)) break;
            end
        end else begin
            v = 0;
            up = 1'b1;
            for (int k = 0; k < 100000; k++) begin
                bit c;
                c = 1'b0;
                exp_ph.push_back(v);
                if (up) begin
                    if (v + se >= PMAX) begin v = PMAX; up = 1'b0; end
                    else v = v + se;
                end else begin
                    if (v <= se) begin v = 0; up = 1'b1; c = 1'b1; end
                    else v = v - se;
                end
                exp_cmp.push_back(c);
                if (c) comp++;
                exp_final = v;
                if ((n != 0 && comp == n) || (n == 0 && exp_ph.size() == limit)) break;
            end
        end
    endtask

    // rdy: 0 = always ready, 1 = toggling 1010..., 2 = random
    task automatic run_sweep(input bit m, input int s, input int n, input int rdy, input int limit);
        int idx, cyc, comps;
        bit pend_sd, pend_ad, done;
        build_expected(m, s, n, limit);
        @(negedge clk_50m);
        mode = m;
        step = SW'(s);
        num_sweeps = NW'(n);
        start = 1'b1;
        @(negedge clk_50m);
        start = 1'b0;
`ifdef CORDIC_SWEEP_ERR_MON_EN
        exp_max = 0;
        check_val("max_err_cleared", max_err, 0);
`endif
        idx = 0; cyc = 0; comps = 0;
        pend_sd = 1'b0; pend_ad = 1'b0; done = 1'b0;
        while (!done) begin
            start = 1'b0;
            check_val("sweep_done", sweep_done, pend_sd);
            check_val("all_done", all_done, pend_ad);
            if (pend_ad) begin
                done = 1'b1;
            end else if (n == 0 && idx == exp_ph.size()) begin
                abort = 1'b1;
                start = 1'b1;
                done = 1'b1;
            end else begin
                check_val("phase_valid", phase_valid, idx < exp_ph.size());
                if (phase_valid && idx < exp_ph.size())
                    check_val("phase", phase, exp_ph[idx]);
                case (rdy)
                    0: phase_ready = 1'b1;
                    1: phase_ready = (cyc % 2 == 0);
                    default: phase_ready = ($urandom_range(0, 1) == 1);
                endcase
                if ($urandom_range(0, 15) == 0) start = 1'b1;
`ifdef CORDIC_SWEEP_ERR_MON_EN
                err = $signed($urandom);
                if ($urandom_range(0, 31) == 0) err = {1'b1, {(EW-1){1'b0}}};
`endif
                pend_sd = 1'b0;
                pend_ad = 1'b0;
                if (phase_valid && phase_ready && idx < exp_ph.size()) begin
`ifdef CORDIC_SWEEP_ERR_MON_EN
                    begin
                        longint a;
                        a = (err < 0) ? -longint'(err) : longint'(err);
                        if (a > 64'sd2147483647) a = 64'sd2147483647;
                        if (a > exp_max) exp_max = a;
                    end
`endif
                    pend_sd = exp_cmp[idx];
                    if (exp_cmp[idx]) comps++;
                    pend_ad = (n != 0) && (idx == exp_ph.size() - 1);
                    idx++;
                end
                @(negedge clk_50m);
                cyc++;
                if (cyc > BUDGET) begin
                    check_val("timeout", cyc, BUDGET);
                    done = 1'b1;
                end
            end
        end
        @(negedge clk_50m);
        abort = 1'b0;
        start = 1'b0;
        check_val("idle_busy", busy, 0);
        check_val("idle_valid", phase_valid, 0);
        check_val("idle_all_done", all_done, 0);
        check_val("sweep_cnt", sweep_cnt, (comps > 255) ? 255 : comps);
        check_val("final_phase", phase, (n == 0) ? 0 : exp_final);
        check_val("accepted", idx, exp_ph.size());
`ifdef CORDIC_SWEEP_ERR_MON_EN
        check_val("max_err", max_err, exp_max);
`endif
        @(negedge clk_50m);
        check_val("still_idle", busy, 0);
    endtask

    initial begin
        int wait_cyc;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; mode = 1'b0; step = '0; num_sweeps = '0; phase_ready = 1'b0;
`ifdef CORDIC_SWEEP_ERR_MON_EN
        err = '0;
`endif
        repeat (3) @(negedge clk_50m);
        check_val("rst_phase", phase, 0);
        check_val("rst_valid", phase_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_sweep_done", sweep_done, 0);
        check_val("rst_all_done", all_done, 0);
        check_val("rst_sweep_cnt", sweep_cnt, 0);
        rst_n = 1'b1;

        // Reset asserted mid-run at phase 120.
        @(negedge clk_50m);
        mode = 1'b0; step = 8'd1; num_sweeps = '0; phase_ready = 1'b1; start = 1'b1;
        @(negedge clk_50m);
        start = 1'b0;
        wait_cyc = 0;
        while (phase != 16'd120 && wait_cyc < 500) begin
            @(negedge clk_50m);
            wait_cyc++;
        end
        check_val("reach_120", phase, 120);
        rst_n = 1'b0;
        #1;
        check_val("midrst_phase", phase, 0);
        check_val("midrst_valid", phase_valid, 0);
        check_val("midrst_busy", busy, 0);
        @(negedge clk_50m);
        rst_n = 1'b1;
        phase_ready = 1'b0;

        run_sweep(1'b0, 1, 1, 0, 0);
        run_sweep(1'b0, 100, 0, 0, 12);
        run_sweep(1'b1, 120, 2, 0, 0);
        run_sweep(1'b1, 120, 2, 1, 0);
        run_sweep(1'b0, 0, 2, 2, 0);
        run_sweep(1'b1, 255, 3, 2, 0);
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(0, 3);
            run_sweep($urandom_range(0, 1) == 1, $urandom_range(0, 255), n, $urandom_range(0, 2), 40);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cordic_phase_sweeper.md
Name: cordic_phase_sweeper

Overview:
- Parametrised phase-stimulus generator that drives the CORDIC phase input during bring-up and self-test.
- Generalises the fixed 0..359 free-running degree counter:
  - configurable range and step;
  - sawtooth or triangle sweep mode;
  - bounded sweep count;
  - valid/ready handshake toward the consumer.
- Sits between the test controller (start/abort) and the CORDIC core.

Parameters:
- PHASE_W, 16, width of phase output in degrees (unsigned).
- PHASE_MAX, 359, last legal phase value; sweep range is 0..PHASE_MAX.
- STEP_W, 8, width of step input.
- SWEEP_W, 8, width of sweep-count input/output.
- ERR_W, 32, width of error input (used only with optional feature).

Ports:
- CLK_50M  in  1  system clock, rising-edge.
- RST_N  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin; sampled in IDLE only.
- abort  in  1  terminate any run; returns to IDLE.
- mode  in  1  0 = sawtooth (wrap), 1 = triangle (up then down); latched at start.
- step  in  STEP_W  phase increment per accepted sample; latched at start; 0 treated as 1.
- num_sweeps  in  SWEEP_W  sweeps to run; 0 = continuous until abort; latched at start.
- phase  out  PHASE_W  current phase value.
- phase_valid  out  1  phase is valid.
- phase_ready  in  1  consumer accepts phase when valid && ready.
- busy  out  1  high in any state except IDLE.
- sweep_done  out  1  one-cycle pulse when a sweep completes.
- all_done  out  1  one-cycle pulse when num_sweeps sweeps complete.
- sweep_cnt  out  SWEEP_W  completed sweeps in the current run; saturates at all-ones.

Behaviour:
- Reset values: phase=0, phase_valid=0, busy=0, sweep_done=0, all_done=0, sweep_cnt=0, state=IDLE. Reset is legal mid-run; all outputs return to reset values immediately.
- FSM states: IDLE, UP, DOWN, DONE.
- IDLE:
  - start=1 latches mode/step/num_sweeps, clears sweep_cnt, sets phase=0, and goes to UP.
  - phase_valid rises the cycle after start (1-cycle latency).
- Handshake:
  - phase advances only on phase_valid && phase_ready.
  - While valid && !ready, phase is held stable and valid stays high.
- Arithmetic: next phase computed PHASE_W+1 bits wide; no silent overflow.
- UP, sawtooth:
  - sum = phase+step.
  - If sum <= PHASE_MAX: phase = sum.
  - Else: phase = sum-(PHASE_MAX+1) (wrap, keeps residue) and the sweep completes.
- UP, triangle:
  - If phase+step >= PHASE_MAX: phase = PHASE_MAX, go DOWN.
  - Else: phase += step.
- DOWN, triangle only:
  - If phase <= step: phase = 0, sweep completes, go UP.
  - Else: phase -= step.
- Sweep completion:
  - sweep_done pulses in the cycle the completing phase value is registered.
  - sweep_cnt increments in the same cycle.
  - If num_sweeps != 0 and the new count equals num_sweeps: go DONE; phase_valid drops in that same cycle (the completing value is not presented).
- DONE: all_done pulses one cycle, then return to IDLE. phase holds its last value; sweep_cnt holds until the next start.
- Abort:
  - From any non-IDLE state: next cycle is IDLE, phase_valid=0, phase=0, no all_done.
  - sweep_cnt keeps its value.
  - abort and start in the same cycle: abort wins and start is ignored.
- start while busy is ignored.
- step >= PHASE_MAX+1 is legal: sawtooth wraps every sample; triangle alternates between PHASE_MAX and 0.

Optional Feature:
- Macro: CORDIC_SWEEP_ERR_MON_EN.
- When defined:
  - Adds input err (ERR_W, signed, sampled on each accepted phase) and output max_err (ERR_W).
  - max_err holds the running maximum of |err| over the current run.
  - max_err is cleared on start, held after DONE or abort, and is 0 at reset.
  - |most-negative| saturates to the positive maximum.
- When undefined: neither port exists and there is no monitor logic.

Test Plan:
- Reset mid-run: assert RST_N=0 while in UP with phase=120 -> phase=0, valid=0, busy=0 immediately.
- Sawtooth, step=1, num_sweeps=1, ready=1:
  - phase sequence 0,1,...,359;
  - valid drops after 359;
  - sweep_done and all_done each pulse once; sweep_cnt=1.
- Sawtooth, step=100, num_sweeps=0: phase 0,100,200,300,40,140,... with sweep_done on 40; runs until abort; no all_done.
- Triangle, step=120, num_sweeps=2: phase 0,120,240,359,239,119,0,120,240,359,239,119, then DONE; all_done pulses once; sweep_cnt=2.
- Backpressure: ready toggles 1010... -> each value held while ready=0, no value skipped or repeated. Abort and start asserted together mid-run -> IDLE, no restart.
- With CORDIC_SWEEP_ERR_MON_EN: err sequence 3,-7,5 on accepted samples -> max_err=7. A new start -> max_err=0.
